fpu_addsub_param: RTL and testbench
===================================

Name: fpu_addsub_param

Overview:
Parametrised floating-point add/subtract unit and the next generation of the team's single-precision FSM adder. Formats are configurable (EXP_W/MAN_W; default IEEE-754 binary32, also binary16). Adds round-to-nearest-even, special-value handling, exception flags and a one-cycle done pulse. Operands are latched at start. Sits behind the datapath's start/ready handshake as a multi-cycle execution unit.

Parameters:
EXP_W, 8, exponent field width (3..11)
MAN_W, 23, stored fraction width, excluding the hidden bit (4..52)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only while ready=1
op  in  1  0 = A+B, 1 = A-B
A  in  1+EXP_W+MAN_W  left operand {sign, exp, frac}
B  in  1+EXP_W+MAN_W  right operand
ready  out  1  high when idle; low while busy
done  out  1  one-cycle pulse when C/flags update
C  out  1+EXP_W+MAN_W  result; held until next done
overflow  out  1  result rounded to infinity (held with C)
invalid  out  1  NaN operand or inf-inf (held with C)
inexact  out  1  rounding discarded nonzero bits (held with C)

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, done=0, C=0, all flags=0. Any in-flight operation is discarded.
- FSM: IDLE -> UNPACK -> ALIGN -> OP -> NORM -> ROUND -> PACK -> IDLE. One cycle per state.
- IDLE: on a clk edge with start=1, latch A, B and op, set ready=0, go to UNPACK. With start=0, stay.
- Latency: start edge = edge 0. At edge 6 (PACK), C and flags are registered, done=1 for that cycle, and ready=1. A start at edge 7 (ready already 1, state IDLE) is accepted. Back-to-back throughput is one op per 7 cycles.
- start while ready=0 is ignored. A, B and op changes after the latch edge have no effect.
- UNPACK: effective sign of B = B.sign XOR op. exp=0 means zero (subnormals flushed to signed zero, frac ignored). Significand = {1'b1, frac}, extended with 3 LSBs (guard, round, sticky).
- ALIGN: the smaller exponent is shifted right by d = |eA - eB|. Bits shifted out OR into sticky. d saturates at MAN_W+3, leaving significand 0 and sticky = OR of all bits. Result exponent = max.
- OP: same signs -> add, with 1 extra carry bit. Different signs -> larger magnitude minus smaller; sign taken from the larger. Equal magnitudes -> +0.
- NORM: carry out -> shift right 1 (shifted-out bit into sticky), exp+1. Otherwise left-shift by leading-zero count, exp -= lzc. If exp <= 0 after shifting, flush to signed zero; inexact=1 if the value was nonzero.
- ROUND (RNE): increment if G & (R | S | LSB). A mantissa carry from the increment renormalises (exp+1). inexact = G|R|S.
- Exp reaching all-ones after NORM/ROUND: C = signed infinity, overflow=1, inexact=1.
- Specials (decided in UNPACK, pass through to PACK):
  - Any NaN operand, or inf + (-inf) effective: C = canonical qNaN {0, all-ones, 1, zeros}, invalid=1.
  - inf with finite: C = that inf, no flags.
  - Both zero: sign = AND of the effective signs (so -0 + -0 = -0, otherwise +0).
- Flags are cleared at each new start and valid from done.

Optional Feature:
FPU_RNE_EN. Defined: round-to-nearest-even as above. Undefined: truncation (round toward zero). The ROUND state still exists, so latency is unchanged. The increment is removed, inexact is still reported, and overflow saturates to max finite {sign, all-ones-1, all-ones frac}. C takes infinity only for an infinity operand.

Test Plan:
- Default params: A=0x3F800000, B=0x40000000, op=0 -> C=0x40400000 at edge 6. done high 1 cycle, ready low edges 0..5, flags 0.
- A=0x40400000, B=0x40400000, op=1 -> C=0x00000000. Then A=0x80000000, B=0x00000000, op=1 -> C=0x80000000.
- FPU_RNE_EN defined: 0x3F800000 + 0x33800000 -> C=0x3F800000, inexact=1 (tie to even). 0x3F800000 + 0x33C00000 -> C=0x3F800001. Undefined: both give 0x3F800000.
- 0x7F7FFFFF + 0x7F7FFFFF -> C=0x7F800000, overflow=1 (macro on); C=0x7F7FFFFF (macro off). 0x7F800000 - 0x7F800000 -> C=0x7FC00000, invalid=1. 0x7FC00001 + 1.0 -> 0x7FC00000, invalid=1.
- EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000. 0x3C00 - 0x4000 -> 0xBC00.
- Protocol: start pulses at edges 2 and 4 during a busy op -> ignored, single done. Assert rst at edge 3 mid-op -> ready=1, C=0, no done. A new start after reset completes correctly.

Source files
------------

// File: rtl/fpu_addsub_param_if.sv
// rtl/fpu_addsub_param_if.sv - start/ready request and result bus of the parametrised FP add/sub unit
interface fpu_addsub_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                   start;
    logic                   op;
    logic [EXP_W+MAN_W:0]   A;
    logic [EXP_W+MAN_W:0]   B;
    logic                   ready;
    logic                   done;
    logic [EXP_W+MAN_W:0]   C;
    logic                   overflow;
    logic                   invalid;
    logic                   inexact;

    modport master (
        output start, op, A, B,
        input  ready, done, C, overflow, invalid, inexact
    );

    modport slave (
        input  start, op, A, B,
        output ready, done, C, overflow, invalid, inexact
    );
endinterface

// File: rtl/fpu_addsub_param.sv
// rtl/fpu_addsub_param.sv - multi-cycle FP add/sub, 7-state FSM; FPU_RNE_EN selects round-to-nearest-even over truncation
module fpu_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    fpu_addsub_param_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;           // hidden + fraction + guard/round/sticky
    localparam int EW = EXP_W + 8;           // working exponent, two's complement, room for lzc underflow
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    EMAX     = {{(EW-EXP_W){1'b0}}, {EXP_W{1'b1}}};
    localparam logic [EW-1:0]    ONE_E    = 1;
    localparam logic [MAN_W+1:0] ONE_M    = 1;
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_OP, S_NORM, S_ROUND, S_PACK} state_t;
    state_t state_q, state_d;

    logic [W-1:0]     a_q, b_q, spec_c_q, rc_q, c_q;
    logic             op_q, sa_q, sb_q, spec_q, spec_inv_q, sign_q, zero_q, wi_q, rovf_q, rinx_q;
    logic             ovf_q, inv_q, inx_q, done_q;
    logic [EXP_W-1:0] ea_q, eb_q;
    logic [SW-1:0]    ma_q, mb_q, m_q;
    logic [SW:0]      sum_q;
    logic [EW-1:0]    e_q;

    // Right shift that folds every shifted-out bit into the sticky LSB; d >= SW leaves only sticky
    function automatic logic [SW-1:0] shr_sticky(input logic [SW-1:0] m, input logic [EXP_W-1:0] d);
        logic [SW-1:0] mask;
        mask = ~({SW{1'b1}} << d);
        return (m >> d) | {{(SW-1){1'b0}}, |(m & mask)};
    endfunction

    function automatic logic [EW-1:0] clz(input logic [SW-1:0] v);
        logic [EW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + ONE_E;
            end
        end
        return n;
    endfunction

    // Stage arithmetic; each state's always_ff branch captures only its own stage's results
    logic             u_sa, u_sb, u_za, u_zb, u_nan_a, u_nan_b, u_inf_a, u_inf_b, u_spec, u_inv;
    logic [EXP_W-1:0] u_ea, u_eb;
    logic [SW-1:0]    u_ma, u_mb, al_ma, al_mb, n_m;
    logic [W-1:0]     u_spec_c, r_c;
    logic [EW-1:0]    al_e, n_e, lz, r_e;
    logic [SW:0]      o_sum;
    logic             o_sign, n_zero, n_inx, r_ovf, r_inx;
    logic [MAN_W+1:0] mant;

    // Unpack, align, add/subtract, normalise and round datapath
    always_comb begin
        u_sa     = a_q[W-1];
        u_sb     = b_q[W-1] ^ op_q;
        u_ea     = a_q[W-2:MAN_W];
        u_eb     = b_q[W-2:MAN_W];
        u_za     = (u_ea == '0);
        u_zb     = (u_eb == '0);
        u_ma     = u_za ? '0 : {1'b1, a_q[MAN_W-1:0], 3'b000};
        u_mb     = u_zb ? '0 : {1'b1, b_q[MAN_W-1:0], 3'b000};
        u_nan_a  = (u_ea == EXP_ONES) && (a_q[MAN_W-1:0] != '0);
        u_nan_b  = (u_eb == EXP_ONES) && (b_q[MAN_W-1:0] != '0);
        u_inf_a  = (u_ea == EXP_ONES) && (a_q[MAN_W-1:0] == '0);
        u_inf_b  = (u_eb == EXP_ONES) && (b_q[MAN_W-1:0] == '0);
        u_spec   = 1'b1;
        u_inv    = 1'b0;
        u_spec_c = '0;
        if (u_nan_a || u_nan_b || (u_inf_a && u_inf_b && (u_sa != u_sb))) begin
            u_spec_c = QNAN;
            u_inv    = 1'b1;
        end else if (u_inf_a) begin
            u_spec_c = {u_sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (u_inf_b) begin
            u_spec_c = {u_sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (u_za && u_zb) begin
            u_spec_c = {u_sa & u_sb, {(W-1){1'b0}}};
        end else begin
            u_spec   = 1'b0;
        end

        // the operand with the smaller exponent is the one shifted
        if (ea_q >= eb_q) begin
            al_ma = ma_q;
            al_mb = shr_sticky(mb_q, ea_q - eb_q);
            al_e  = {{(EW-EXP_W){1'b0}}, ea_q};
        end else begin
            al_ma = shr_sticky(ma_q, eb_q - ea_q);
            al_mb = mb_q;
            al_e  = {{(EW-EXP_W){1'b0}}, eb_q};
        end

        if (sa_q == sb_q) begin
            o_sum  = {1'b0, ma_q} + {1'b0, mb_q};
            o_sign = sa_q;
        end else if (ma_q > mb_q) begin
            o_sum  = {1'b0, ma_q - mb_q};
            o_sign = sa_q;
        end else if (mb_q > ma_q) begin
            o_sum  = {1'b0, mb_q - ma_q};
            o_sign = sb_q;
        end else begin
            o_sum  = '0;
            o_sign = 1'b0;
        end

        lz     = clz(sum_q[SW-1:0]);
        n_m    = '0;
        n_e    = e_q;
        n_zero = 1'b0;
        n_inx  = 1'b0;
        if (sum_q[SW]) begin
            n_m = sum_q[SW:1] | {{(SW-1){1'b0}}, sum_q[0]};
            n_e = e_q + ONE_E;
        end else if (sum_q == '0) begin
            n_zero = 1'b1;
        end else begin
            n_m = sum_q[SW-1:0] << lz;
            n_e = e_q - lz;
            if (n_e[EW-1] || (n_e == '0)) begin
                n_m    = '0;
                n_zero = 1'b1;
                n_inx  = 1'b1;
            end
        end

        r_inx = wi_q | (|m_q[2:0]);
        r_ovf = 1'b0;
        mant  = {1'b0, m_q[SW-1:3]};
`ifdef FPU_RNE_EN
        if (m_q[2] & (m_q[1] | m_q[0] | m_q[3])) mant = mant + ONE_M;
`endif
        r_e = e_q;
        if (mant[MAN_W+1]) begin
            mant = mant >> 1;
            r_e  = e_q + ONE_E;
        end
        if (zero_q) begin
            r_c = {sign_q, {(W-1){1'b0}}};
        end else if (!r_e[EW-1] && (r_e >= EMAX)) begin
            r_ovf = 1'b1;
            r_inx = 1'b1;
`ifdef FPU_RNE_EN
            r_c   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
`else
            r_c   = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
        end else begin
            r_c = {sign_q, r_e[EXP_W-1:0], mant[MAN_W-1:0]};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: one cycle per stage, only IDLE waits on start
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_UNPACK;
            S_UNPACK: state_d = S_ALIGN;
            S_ALIGN:  state_d = S_OP;
            S_OP:     state_d = S_NORM;
            S_NORM:   state_d = S_ROUND;
            S_ROUND:  state_d = S_PACK;
            S_PACK:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Per-stage pipeline registers and the held result/flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0; b_q <= '0; op_q <= 1'b0;
            sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
            spec_q <= 1'b0; spec_c_q <= '0; spec_inv_q <= 1'b0;
            e_q <= '0; sum_q <= '0; sign_q <= 1'b0; m_q <= '0; zero_q <= 1'b0; wi_q <= 1'b0;
            rc_q <= '0; rovf_q <= 1'b0; rinx_q <= 1'b0;
            c_q <= '0; ovf_q <= 1'b0; inv_q <= 1'b0; inx_q <= 1'b0; done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (bus.start) begin
                    a_q   <= bus.A;
                    b_q   <= bus.B;
                    op_q  <= bus.op;
                    ovf_q <= 1'b0;
                    inv_q <= 1'b0;
                    inx_q <= 1'b0;
                end
                S_UNPACK: begin
                    sa_q <= u_sa; sb_q <= u_sb; ea_q <= u_ea; eb_q <= u_eb;
                    ma_q <= u_ma; mb_q <= u_mb;
                    spec_q <= u_spec; spec_c_q <= u_spec_c; spec_inv_q <= u_inv;
                end
                S_ALIGN: begin ma_q <= al_ma; mb_q <= al_mb; e_q <= al_e; end
                S_OP:    begin sum_q <= o_sum; sign_q <= o_sign; end
                S_NORM:  begin m_q <= n_m; e_q <= n_e; zero_q <= n_zero; wi_q <= n_inx; end
                S_ROUND: begin rc_q <= r_c; rovf_q <= r_ovf; rinx_q <= r_inx; end
                S_PACK: begin
                    c_q    <= spec_q ? spec_c_q : rc_q;
                    ovf_q  <= !spec_q && rovf_q;
                    inv_q  <= spec_q && spec_inv_q;
                    inx_q  <= !spec_q && rinx_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = (state_q == S_IDLE);
    assign bus.done     = done_q;
    assign bus.C        = c_q;
    assign bus.overflow = ovf_q;
    assign bus.invalid  = inv_q;
    assign bus.inexact  = inx_q;
endmodule

// File: tb/tb_fpu_addsub_param.sv
// tb/tb_fpu_addsub_param.sv - directed-vector bench for fpu_addsub_param (binary32 and binary16 instances)
module tb_fpu_addsub_param;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fpu_addsub_param_if #(.EXP_W(8), .MAN_W(23)) b32 ();
    fpu_addsub_param_if #(.EXP_W(5), .MAN_W(10)) b16 ();

    fpu_addsub_param #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    fpu_addsub_param #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (lat = edges after the start edge)
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic o,
                         output int lat, output logic busy_rdy);
        b32.A = a; b32.B = b; b32.op = o; b32.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b32.start = 1'b0; b32.A = '1; b32.B = '1; b32.op = ~o;
        lat = 0;
        busy_rdy = 1'b0;
        while (!b32.done && lat < 20) begin
            busy_rdy |= b32.ready;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic vec32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic o,
                         input logic [31:0] ec, input logic [2:0] ef, input logic [2:0] fmask);
        int   lat;
        logic br;
        run32(a, b, o, lat, br);
        check({tag, ".lat"}, 32'(lat), 32'd6);
        check({tag, ".C"}, b32.C, ec);
        check({tag, ".flags"}, 32'({b32.overflow, b32.invalid, b32.inexact} & fmask), 32'(ef & fmask));
    endtask

    task automatic vec16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic o,
                         input logic [15:0] ec);
        int lat;
        b16.A = a; b16.B = b; b16.op = o; b16.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b16.start = 1'b0;
        lat = 0;
        while (!b16.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'd6);
        check({tag, ".C"}, 32'(b16.C), 32'(ec));
    endtask

    initial begin
        int   lat;
        int   ndone;
        logic br;

        rst = 1'b1;
        b32.start = 1'b0; b32.op = 1'b0; b32.A = '0; b32.B = '0;
        b16.start = 1'b0; b16.op = 1'b0; b16.A = '0; b16.B = '0;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(b32.ready), 32'd1);
        check("rst.done", 32'(b32.done), 32'd0);
        check("rst.C", b32.C, 32'h0);
        check("rst.flags", 32'({b32.overflow, b32.invalid, b32.inexact}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1.0 + 2.0 with full protocol observation
        run32(32'h3F800000, 32'h40000000, 1'b0, lat, br);
        check("add.lat", 32'(lat), 32'd6);
        check("add.busy_ready", 32'(br), 32'd0);
        check("add.ready_at_done", 32'(b32.ready), 32'd1);
        check("add.C", b32.C, 32'h40400000);
        check("add.flags", 32'({b32.overflow, b32.invalid, b32.inexact}), 32'd0);
        @(negedge clk);
        check("add.done_pulse", 32'(b32.done), 32'd0);

        vec32("sub_eq", 32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 3'b000, 3'b111);
        vec32("negz", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, 3'b111);
`ifdef FPU_RNE_EN
        vec32("tie", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 3'b111);
        vec32("above", 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001, 3'b111);
        vec32("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b101, 3'b111);
`else
        vec32("tie", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 3'b111);
        vec32("above", 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 3'b001, 3'b111);
        vec32("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 3'b000, 3'b000);
`endif
        vec32("inf_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b010, 3'b111);
        vec32("nan", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b010, 3'b111);
        vec32("inf_fin", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000, 3'b111);

        vec16("h_add", 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
        vec16("h_sub", 16'h3C00, 16'h4000, 1'b1, 16'hBC00);

        // starts pulsed during a busy op are ignored
        @(negedge clk);
        b32.A = 32'h3F800000; b32.B = 32'h40000000; b32.op = 1'b0; b32.start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            b32.start = (k == 1 || k == 3);
            b32.A = 32'h40400000; b32.B = 32'h40400000;
            if (b32.done) ndone++;
        end
        check("busy_start.ndone", 32'(ndone), 32'd1);
        check("busy_start.C", b32.C, 32'h40400000);

        // reset mid-operation, then a fresh operation
        b32.A = 32'h40000000; b32.B = 32'h40000000; b32.op = 1'b0; b32.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b32.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.ready", 32'(b32.ready), 32'd1);
        check("midrst.C", b32.C, 32'h0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b0;
            if (b32.done) ndone++;
        end
        check("midrst.ndone", 32'(ndone), 32'd0);
        vec32("after_rst", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000, 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
